alu_acc: RTL and testbench

- Parametrised, registered accumulator ALU that succeeds the 8-bit combinational ALU.
- Holds the accumulator internally and updates condition flags (Z, C, N, V) on every executed operation.
- Accepts operations through a valid/ready handshake and adds shift, rotate, increment/decrement and a multi-cycle shift-add multiplier.
- Sits between the instruction decoder (operation source) and the register/memory datapath (consumer of `accum` and the flags).

---
 rtl/alu_acc_pkg.sv | 26 ++
 rtl/alu_acc_mul.sv | 48 ++++
 rtl/alu_acc.sv | 128 ++++++++++++
 tb/tb_alu_acc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_pkg.sv
// rtl/alu_acc_pkg.sv - opcode map and FSM state encoding for the accumulator ALU
package alu_acc_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_NOT  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_NOP  = 4'h6;
    localparam logic [3:0] OP_LOAD = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_CLR  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_DEC  = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_acc_mul.sv
// rtl/alu_acc_mul.sv - iterative shift-add unsigned multiplier, one partial-product step per cycle
module alu_acc_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] part;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;

    // product is the value the partial product takes after the current step,
    // so on the final step (done) it already holds the complete result
    always_comb begin
        sum     = {1'b0, part[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        product = {sum, part[WIDTH-1:1]};
    end

    assign done = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            part   <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            part   <= '0;
            cnt    <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            part   <= product;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_acc.sv
// rtl/alu_acc.sv - registered accumulator ALU with flags, valid/ready issue and multi-cycle MUL
module alu_acc
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opecode,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] accum,
    output logic [WIDTH-1:0] acc_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic             out_valid,
    output logic             busy
);

    state_t state, state_nxt;
    logic   accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] addend, res;
    logic [WIDTH:0]   sum_add, sum_sub;
    logic             v_add, v_sub, c_new, v_new;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_MUL);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opecode == OP_MUL);

    alu_acc_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (accum),
        .b       (data),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // INC/DEC share the ADD/SUB adders with a constant operand of one
    assign addend  = (opecode == OP_INC || opecode == OP_DEC) ? WIDTH'(1) : data;
    assign sum_add = {1'b0, accum} + {1'b0, addend};
    assign sum_sub = {1'b0, accum} - {1'b0, addend};
    assign v_add   = (accum[WIDTH-1] == addend[WIDTH-1]) && (sum_add[WIDTH-1] != accum[WIDTH-1]);
    assign v_sub   = (accum[WIDTH-1] != addend[WIDTH-1]) && (sum_sub[WIDTH-1] != accum[WIDTH-1]);

    always_comb begin
        res   = accum;
        c_new = 1'b0;
        v_new = 1'b0;
        case (opecode)
            OP_AND:  res = accum & data;
            OP_OR:   res = accum | data;
            OP_NOT:  res = ~accum;
            OP_XOR:  res = accum ^ data;
            OP_LOAD: res = data;
            OP_CLR:  res = '0;
            OP_ADD, OP_INC: begin
                res   = sum_add[WIDTH-1:0];
                c_new = sum_add[WIDTH];
                v_new = v_add;
            end
            OP_SUB, OP_DEC: begin
                res   = sum_sub[WIDTH-1:0];
                c_new = sum_sub[WIDTH];
                v_new = v_sub;
            end
            OP_SHL: begin res = {accum[WIDTH-2:0], 1'b0};           c_new = accum[WIDTH-1]; end
            OP_SHR: begin res = {1'b0, accum[WIDTH-1:1]};           c_new = accum[0];       end
            OP_ROL: begin res = {accum[WIDTH-2:0], accum[WIDTH-1]}; c_new = accum[WIDTH-1]; end
            OP_ROR: begin res = {accum[0], accum[WIDTH-1:1]};       c_new = accum[0];       end
            default: res = accum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            accum     <= '0;
            acc_hi    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (state == ST_MUL) begin
                if (mul_done) begin
                    {acc_hi, accum} <= mul_product;
                    flag_z    <= (mul_product == '0);
                    flag_n    <= mul_product[WIDTH-1];
                    flag_c    <= |mul_product[2*WIDTH-1:WIDTH];
                    flag_v    <= 1'b0;
                    out_valid <= 1'b1;
                end
            end else if (accept && opecode != OP_MUL) begin
                out_valid <= 1'b1;
                if (opecode != OP_NOP) begin
                    accum  <= res;
                    acc_hi <= '0;
                    flag_z <= (res == '0);
                    flag_n <= res[WIDTH-1];
                    flag_c <= c_new;
                    flag_v <= v_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_acc.sv
// tb/tb_alu_acc.sv - randomized and directed self-checking bench for alu_acc (WIDTH 8 and 16)
module tb_alu_acc;
    import alu_acc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v8 = 1'b0, rdy8, z8, c8, n8, vf8, ov8, busy8;
    logic [3:0]  op8 = 4'h6;
    logic [7:0]  d8 = '0, acc8, hi8;
    logic        v16 = 1'b0, rdy16, z16, c16, n16, vf16, ov16, busy16;
    logic [3:0]  op16 = 4'h6;
    logic [15:0] d16 = '0, acc16, hi16;

    alu_acc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .opecode(op8), .data(d8),
        .accum(acc8), .acc_hi(hi8), .flag_z(z8), .flag_c(c8), .flag_n(n8), .flag_v(vf8),
        .out_valid(ov8), .busy(busy8)
    );

    alu_acc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .opecode(op16), .data(d16),
        .accum(acc16), .acc_hi(hi16), .flag_z(z16), .flag_c(c16), .flag_n(n16), .flag_v(vf16),
        .out_valid(ov16), .busy(busy16)
    );

    int passed = 0;
    int total  = 0;

    logic [63:0] m_acc [2];
    logic [63:0] m_hi  [2];
    bit          m_z [2], m_c [2], m_n [2], m_v [2];

    logic [63:0] o_acc, o_hi;
    logic [3:0]  o_f;
    logic [2:0]  o_st;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = '0; m_hi[i] = '0;
            m_z[i] = 0; m_c[i] = 0; m_n[i] = 0; m_v[i] = 0;
        end
    endfunction

    // reference: plain integer arithmetic on the operand values
    function automatic void model_op(input int i, input logic [3:0] op, input logic [63:0] b);
        int     w    = (i == 0) ? 8 : 16;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint a    = longint'(m_acc[i]);
        longint bb   = longint'(b);
        longint r, sa, sb, s;
        bit     c = 0, v = 0;
        if (op == OP_INC || op == OP_DEC) bb = 1;
        sa = (a >= half) ? a - 2 * half : a;
        sb = (bb >= half) ? bb - 2 * half : bb;
        r  = a;
        case (op)
            OP_AND:  r = a & bb;
            OP_OR:   r = a | bb;
            OP_NOT:  r = ~a;
            OP_XOR:  r = a ^ bb;
            OP_LOAD: r = bb;
            OP_CLR:  r = 0;
            OP_ADD, OP_INC: begin r = a + bb; c = (r > mask); s = sa + sb; v = (s >= half) || (s < -half); end
            OP_SUB, OP_DEC: begin r = a - bb; c = (a < bb);   s = sa - sb; v = (s >= half) || (s < -half); end
            OP_SHL: begin r = a << 1; c = ((a >> (w - 1)) & 1) != 0; end
            OP_SHR: begin r = a >> 1; c = (a & 1) != 0; end
            OP_ROL: begin r = (a << 1) | (a >> (w - 1)); c = ((a >> (w - 1)) & 1) != 0; end
            OP_ROR: begin r = (a >> 1) | ((a & 1) << (w - 1)); c = (a & 1) != 0; end
            OP_NOP: return;
            OP_MUL: begin
                r = a * bb;
                m_acc[i] = r & mask;
                m_hi[i]  = r >> w;
                m_z[i]   = (r == 0);
                m_n[i]   = ((r >> (w - 1)) & 1) != 0;
                m_c[i]   = (m_hi[i] != 0);
                m_v[i]   = 0;
                return;
            end
            default: r = a;
        endcase
        r = r & mask;
        m_acc[i] = r; m_hi[i] = '0;
        m_z[i] = (r == 0); m_n[i] = ((r >> (w - 1)) & 1) != 0; m_c[i] = c; m_v[i] = v;
    endfunction

    function automatic void drive(input int i, input logic v, input logic [3:0] op, input logic [63:0] d);
        if (i == 0) begin v8 = v; op8 = op; d8 = d[7:0]; end
        else        begin v16 = v; op16 = op; d16 = d[15:0]; end
    endfunction

    function automatic void sample(input int i);
        if (i == 0) begin
            o_acc = 64'(acc8); o_hi = 64'(hi8); o_f = {z8, c8, n8, vf8}; o_st = {ov8, rdy8, busy8};
        end else begin
            o_acc = 64'(acc16); o_hi = 64'(hi16); o_f = {z16, c16, n16, vf16}; o_st = {ov16, rdy16, busy16};
        end
    endfunction

    // called at a falling edge; returns at the falling edge after the accept edge
    task automatic do_op(input int i, input logic [3:0] op, input logic [63:0] d);
        drive(i, 1'b1, op, d);
        @(posedge clk);
        @(negedge clk);
        drive(i, 1'b0, OP_NOP, 64'd0);
        model_op(i, op, d);
        sample(i);
    endtask

    // bad counts busy cycles whose state or held accumulator was wrong
    task automatic do_mul(input int i, input logic [63:0] d, output int bad);
        int w = (i == 0) ? 8 : 16;
        bad = 0;
        drive(i, 1'b1, OP_MUL, d);
        @(posedge clk);
        for (int j = 0; j < w; j++) begin
            @(negedge clk);
            sample(i);
            if (o_st !== 3'b001 || o_acc !== m_acc[i] || o_hi !== m_hi[i]) bad++;
            drive(i, (j % 2) == 1, OP_LOAD, 64'($urandom_range(0, 255)));
            @(posedge clk);
        end
        @(negedge clk);
        drive(i, 1'b0, OP_NOP, 64'd0);
        model_op(i, OP_MUL, d);
        sample(i);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            sample(i);
            total++;
            if ({o_acc, o_hi, o_f, o_st} !== {64'd0, 64'd0, 4'b0000, 3'b010}) begin
                $display("FAIL reset[%0d] acc=%h hi=%h zcnv=%b st=%b expected 0 0 0000 010", i, o_acc, o_hi, o_f, o_st);
            end else passed++;
        end
    endtask

    task automatic test_logic_back_to_back();
        do_op(0, OP_LOAD, 64'h3C);
        total++;
        if ({o_acc, o_st} !== {64'h3C, 3'b110}) $display("FAIL load3c acc=%h st=%b expected 3c 110", o_acc, o_st);
        else passed++;
        do_op(0, OP_AND, 64'h0F);
        total++;
        if ({o_acc, o_f, o_st} !== {64'h0C, 4'b0000, 3'b110})
            $display("FAIL and0f acc=%h zcnv=%b st=%b expected 0c 0000 110", o_acc, o_f, o_st);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        sample(0);
        total++;
        if (o_st !== 3'b010) $display("FAIL ov_single_pulse st=%b expected 010", o_st);
        else passed++;
    endtask

    task automatic test_arith();
        do_op(0, OP_LOAD, 64'h7F);
        do_op(0, OP_ADD, 64'h01);
        total++;
        if ({o_acc, o_hi, o_f} !== {64'h80, 64'd0, 4'b0011})
            $display("FAIL add_ovf acc=%h hi=%h zcnv=%b expected 80 0 0011", o_acc, o_hi, o_f);
        else passed++;
        do_op(0, OP_SUB, 64'h81);
        total++;
        if ({o_acc, o_f} !== {64'hFF, 4'b0110}) $display("FAIL sub_borrow acc=%h zcnv=%b expected ff 0110", o_acc, o_f);
        else passed++;
    endtask

    task automatic test_shift_dec();
        logic [63:0] exp_acc [4];
        logic [3:0]  exp_f   [4];
        logic [3:0]  ops     [4];
        ops = '{OP_ROL, OP_SHR, OP_DEC, OP_DEC};
        exp_acc = '{64'h03, 64'h01, 64'h00, 64'hFF};
        exp_f   = '{4'b0100, 4'b0100, 4'b1000, 4'b0110};
        do_op(0, OP_LOAD, 64'h81);
        for (int k = 0; k < 4; k++) begin
            do_op(0, ops[k], 64'h0);
            total++;
            if ({o_acc, o_f} !== {exp_acc[k], exp_f[k]})
                $display("FAIL shift_dec[%0d] acc=%h zcnv=%b expected %h %b", k, o_acc, o_f, exp_acc[k], exp_f[k]);
            else passed++;
        end
    endtask

    task automatic test_mul_ff();
        int bad;
        do_op(0, OP_LOAD, 64'hFF);
        do_mul(0, 64'hFF, bad);
        total++;
        if (bad !== 0) $display("FAIL mul_busy bad_cycles=%0d expected 0", bad);
        else passed++;
        total++;
        if ({o_acc, o_hi, o_f, o_st} !== {64'h01, 64'hFE, 4'b0100, 3'b110})
            $display("FAIL mul_ff acc=%h hi=%h zcnv=%b st=%b expected 01 fe 0100 110", o_acc, o_hi, o_f, o_st);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        sample(0);
        total++;
        if (o_st !== 3'b010) $display("FAIL mul_ov_pulse st=%b expected 010", o_st);
        else passed++;
    endtask

    task automatic test_mul_reset();
        int bad = 0;
        do_op(0, OP_LOAD, 64'h10);
        drive(0, 1'b1, OP_MUL, 64'h10);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, OP_NOP, 64'd0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        sample(0);
        total++;
        if ({o_acc, o_hi, o_f, o_st} !== {64'd0, 64'd0, 4'b0000, 3'b010})
            $display("FAIL mul_abort acc=%h hi=%h zcnv=%b st=%b expected 0 0 0000 010", o_acc, o_hi, o_f, o_st);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            sample(0);
            if (o_st !== 3'b010 || o_acc !== 64'd0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL mul_abort_quiet bad_cycles=%0d expected 0", bad);
        else passed++;
    endtask

    task automatic test_w16();
        int bad;
        do_op(1, OP_LOAD, 64'hFFFF);
        do_op(1, OP_INC, 64'h0);
        total++;
        if ({o_acc, o_f, o_st} !== {64'h0000, 4'b1100, 3'b110})
            $display("FAIL w16_inc acc=%h zcnv=%b st=%b expected 0000 1100 110", o_acc, o_f, o_st);
        else passed++;
        do_op(1, OP_LOAD, 64'h0100);
        do_mul(1, 64'h0100, bad);
        total++;
        if (bad !== 0) $display("FAIL w16_mul_busy bad_cycles=%0d expected 0", bad);
        else passed++;
        total++;
        if ({o_acc, o_hi, o_f, o_st} !== {64'h0000, 64'h0001, 4'b0100, 3'b110})
            $display("FAIL w16_mul acc=%h hi=%h zcnv=%b st=%b expected 0000 0001 0100 110", o_acc, o_hi, o_f, o_st);
        else passed++;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [63:0] d;
        int          bad;
        for (int k = 0; k < 80; k++) begin
            op  = 4'($urandom_range(0, 15));
            d   = 64'($urandom_range(0, 255));
            bad = 0;
            if (op == OP_MUL) do_mul(0, d, bad);
            else              do_op(0, op, d);
            total++;
            if (bad != 0 || {o_acc, o_hi, o_f, o_st} !== {m_acc[0], m_hi[0], m_z[0], m_c[0], m_n[0], m_v[0], 3'b110})
                $display("FAIL rnd[%0d] op=%h d=%h acc=%h/%h hi=%h/%h zcnv=%b/%b st=%b/110 busy_bad=%0d",
                         k, op, d, o_acc, m_acc[0], o_hi, m_hi[0], o_f,
                         {m_z[0], m_c[0], m_n[0], m_v[0]}, o_st, bad);
            else passed++;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_logic_back_to_back();
        test_arith();
        test_shift_dec();
        test_mul_ff();
        test_mul_reset();
        test_w16();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
